// File: rtl/pulse_evt_merge.sv
// Buffers single-cycle event strobes in per-channel FIFOs and merges them round-robin
// onto one back-pressured valid/ready stream tagged with the source channel.
module pulse_evt_merge #(
  parameter int NCH      = 4,
  parameter int W        = 32,
  parameter int DEPTH    = 4,
  parameter int CW       = 8,
  parameter int EDGE_DET = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NCH-1:0]                          in_en,
  input  logic [NCH*W-1:0]                        in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [W-1:0]                            out_data,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
  input  logic                                    clr_ovf,
  output logic [NCH-1:0]                          ovf,
  output logic [NCH*CW-1:0]                       drop_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state;
  logic [CHW-1:0] rr_ptr;
  logic [CHW-1:0] lock_ch;
  logic [CHW-1:0] grant_idle;
  logic [CHW-1:0] grant;
  logic [NCH-1:0] in_en_q;
  logic [NCH-1:0] ev;
  logic [NCH-1:0] full;
  logic [NCH-1:0] nonempty;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] push;
  logic [NCH-1:0] drop;
  logic           hs;

  logic [AW:0]   wr_ptr [NCH];
  logic [AW:0]   rd_ptr [NCH];
  logic [W-1:0]  mem    [NCH][DEPTH];
  logic [CW-1:0] cnt    [NCH];

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] c);
    return (c == CHW'(NCH - 1)) ? '0 : c + 1'b1;
  endfunction

  assign ev = (EDGE_DET != 0) ? (in_en & ~in_en_q) : in_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      nonempty[i] = (wr_ptr[i] != rd_ptr[i]);
      full[i]     = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                    (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
    end
  end

  always_comb begin
    int  idx;
    logic found;
    grant_idle = '0;
    found      = 1'b0;
    idx        = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!found && nonempty[idx]) begin
        found      = 1'b1;
        grant_idle = CHW'(idx);
      end
    end
  end

  assign grant     = (state == LOCKED) ? lock_ch : grant_idle;
  assign out_valid = |nonempty;
  assign out_ch    = grant;
  assign out_data  = mem[grant][rd_ptr[grant][AW-1:0]];
  assign hs        = out_valid & out_ready;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is then accepted.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pop[i]  = hs && (grant == CHW'(i));
      push[i] = ev[i] & (~full[i] | pop[i]);
      drop[i] = ev[i] & full[i] & ~pop[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_ch <= '0;
      in_en_q <= '0;
      ovf     <= '0;
      for (int i = 0; i < NCH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      in_en_q <= in_en;
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (drop[i]) begin
          ovf[i] <= 1'b1;
          cnt[i] <= clr_ovf ? CW'(1) : sat_inc(cnt[i]);
        end else if (clr_ovf) begin
          ovf[i] <= 1'b0;
          cnt[i] <= '0;
        end
      end
      case (state)
        IDLE: begin
          if (out_valid && !out_ready) begin
            state   <= LOCKED;
            lock_ch <= grant_idle;
          end else if (hs) begin
            rr_ptr <= next_ch(grant_idle);
          end
        end
        LOCKED: begin
          if (hs) begin
            state  <= IDLE;
            rr_ptr <= next_ch(lock_ch);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= in_data[i*W +: W];
    end
  end

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_cnt
      assign drop_cnt[g*CW +: CW] = cnt[g];
    end
  endgenerate

endmodule
